bsm_operand_driver: RTL

Bit-serial transmit front end for the bit-serial multiplier `BSM`. It accepts a pair of parallel signed operands and their widths through a valid/ready handshake, range-checks them, then drives `BSM` directly. It generates the `start` pulse and streams both operands LSB-first with sign extension until `BSM` raises `done`. It then captures the parallel product and returns it through a second valid/ready handshake.

---
 rtl/bsm_pkg.sv | 41 ++++
 rtl/bsm_bit_sel.sv | 27 ++
 rtl/bsm_operand_driver.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bsm_pkg.sv
// -----------------------------------------------------------------------------
// bsm_pkg
//   Shared types and helpers for the bit-serial multiplier front end.
//   - drv_state_t : operand driver FSM states
//   - BSM_DW      : default operand/product container width
//   - width_t     : 5-bit declared signed width (legal 2..31)
//   - fits_signed : range check of a value against a declared signed width,
//                   also intended for reuse by a result checker
// -----------------------------------------------------------------------------
package bsm_pkg;

    localparam int BSM_DW = 32;
    localparam int W_BITS = 5;

    typedef logic [W_BITS-1:0] width_t;

    localparam width_t W_MIN = width_t'(2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_RESP
    } drv_state_t;

    // True when width is legal (2..31) and value equals itself sign-extended
    // from bit width-1. The caller sign-extends its operand into 64 bits, so
    // every bit above width-1 must be a copy of bit width-1.
    function automatic logic fits_signed(input logic [63:0] value, input width_t width);
        logic   ok;
        width_t msb;
        ok  = (width >= W_MIN);
        msb = width - width_t'(1);
        for (int i = 0; i < 64; i++) begin
            if (i >= int'(msb) && value[i] != value[msb])
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bsm_bit_sel.sv
// -----------------------------------------------------------------------------
// bsm_bit_sel
//   Combinational saturating bit-select: returns operand_i[k_i], or the sign
//   bit operand_i[DW-1] once k_i reaches or exceeds DW-1. This lets the
//   serial stream keep sign-extending for as long as the multiplier asks.
//   Ports:
//     operand_i  in  DW  parallel operand
//     k_i        in  KW  bit index (one spare bit so DW itself is representable)
//     bit_o      out 1   selected bit
// -----------------------------------------------------------------------------
module bsm_bit_sel #(
    parameter int DW = 32,
    parameter int IW = $clog2(DW),
    parameter int KW = IW + 1
) (
    input  logic [DW-1:0] operand_i,
    input  logic [KW-1:0] k_i,
    output logic          bit_o
);

    always_comb begin
        bit_o = operand_i[DW-1];
        if (k_i < KW'(DW - 1))
            bit_o = operand_i[k_i[IW-1:0]];
    end

endmodule

// File: rtl/bsm_operand_driver.sv
// -----------------------------------------------------------------------------
// bsm_operand_driver
//   Bit-serial transmit front end for the BSM multiplier. Accepts a pair of
//   signed operands plus declared widths, range-checks them, pulses start,
//   streams both operands LSB-first (sign bit held once the index saturates)
//   until BSM raises done, then returns the captured product.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   request handshake; in_a/in_b operands, in_wa/in_wb widths
//     start               one-cycle start pulse to BSM
//     WA, WB              widths to BSM, held from acceptance onward
//     bitAin, bitBin      serial operand bits to BSM
//     O, done             product and product-valid strobe from BSM
//     res_valid/res_ready result handshake; res_o product, res_err error flag
// -----------------------------------------------------------------------------
module bsm_operand_driver
    import bsm_pkg::*;
#(
    parameter int DW      = BSM_DW,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [4:0]    in_wa,
    input  logic [4:0]    in_wb,
    output logic          start,
    output logic [4:0]    WA,
    output logic [4:0]    WB,
    output logic          bitAin,
    output logic          bitBin,
    input  logic [DW-1:0] O,
    input  logic          done,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_o,
    output logic          res_err
);

    localparam int IW = $clog2(DW);
    localparam int KW = IW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    drv_state_t     state_q;
    logic [DW-1:0]  a_q, b_q;
    width_t         wa_q, wb_q;
    logic [KW-1:0]  k_q;
    logic [TW-1:0]  tmo_q;
    logic           in_ready_q;
    logic           start_q;
    logic           bit_a_q, bit_b_q;
    logic           res_valid_q;
    logic           res_err_q;
    logic [DW-1:0]  res_o_q;

    // Request legality, evaluated on the raw inputs at acceptance.
    logic [63:0]    a_ext, b_ext;
    logic           req_legal;

    assign a_ext     = 64'($signed(in_a));
    assign b_ext     = 64'($signed(in_b));
    assign req_legal = fits_signed(a_ext, in_wa) && fits_signed(b_ext, in_wb);

    // Serial outputs are registered, so the bit for the *next* cycle is
    // selected from k_q+1. k_q never exceeds DW-1, so k_d fits in KW bits and
    // the selector saturates it back to the sign bit.
    logic [KW-1:0]  k_d;
    logic           sel_a, sel_b;

    assign k_d = k_q + KW'(1);

    bsm_bit_sel #(.DW(DW)) u_sel_a (
        .operand_i (a_q),
        .k_i       (k_d),
        .bit_o     (sel_a)
    );

    bsm_bit_sel #(.DW(DW)) u_sel_b (
        .operand_i (b_q),
        .k_i       (k_d),
        .bit_o     (sel_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            wa_q        <= '0;
            wb_q        <= '0;
            k_q         <= '0;
            tmo_q       <= '0;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            bit_a_q     <= 1'b0;
            bit_b_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_o_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        wa_q       <= in_wa;
                        wb_q       <= in_wb;
                        k_q        <= '0;
                        tmo_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (req_legal) begin
                            state_q <= ST_START;
                            start_q <= 1'b1;
                            bit_a_q <= in_a[0];
                            bit_b_q <= in_b[0];
                        end else begin
                            // Rejected without ever touching BSM.
                            state_q     <= ST_RESP;
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b1;
                            res_o_q     <= '0;
                        end
                    end
                end

                ST_START: begin
                    // done is ignored here; BSM has only seen bit 0.
                    state_q <= ST_SHIFT;
                    start_q <= 1'b0;
                    k_q     <= k_d;
                    bit_a_q <= sel_a;
                    bit_b_q <= sel_b;
                end

                ST_SHIFT: begin
                    if (k_q != KW'(DW - 1))
                        k_q <= k_d;
                    tmo_q <= tmo_q + TW'(1);
                    // done is checked first so it wins over a coincident timeout.
                    if (done) begin
                        state_q     <= ST_RESP;
                        res_valid_q <= 1'b1;
                        res_o_q     <= O;
                        res_err_q   <= 1'b0;
                        bit_a_q     <= 1'b0;
                        bit_b_q     <= 1'b0;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_q     <= ST_RESP;
                        res_valid_q <= 1'b1;
                        res_o_q     <= '0;
                        res_err_q   <= 1'b1;
                        bit_a_q     <= 1'b0;
                        bit_b_q     <= 1'b0;
                    end else begin
                        bit_a_q <= sel_a;
                        bit_b_q <= sel_b;
                    end
                end

                ST_RESP: begin
                    // res_o/res_err stay put until the consumer takes them.
                    if (res_ready) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign start     = start_q;
    assign WA        = wa_q;
    assign WB        = wb_q;
    assign bitAin    = bit_a_q;
    assign bitBin    = bit_b_q;
    assign res_valid = res_valid_q;
    assign res_o     = res_o_q;
    assign res_err   = res_err_q;

endmodule
